// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and defaults for the instruction-memory loader
package imem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int         ADDR_W_DFLT    = 8;
  localparam int         INSTR_W_DFLT   = 9;
  localparam logic [8:0] FILL_WORD_DFLT = 9'h1FF;

  // States in which the loader stream may hand us a word.
  function automatic logic accepts_input(state_e s);
    return (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - loader stream, fetch port and status bundle
interface imem_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_last;
  logic               in_ready;
  logic [15:0]        fetch_addr;
  logic [INSTR_W-1:0] fetch_instr;
  logic               cpu_run;
  logic               error;
  logic [ADDR_W:0]    load_count;

  modport master (
    output in_valid, in_data, in_last, fetch_addr,
    input  in_ready, fetch_instr, cpu_run, error, load_count
  );

  modport slave (
    input  in_valid, in_data, in_last, fetch_addr,
    output in_ready, fetch_instr, cpu_run, error, load_count
  );
endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - simple dual-port RAM, synchronous write, registered read
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // No reset: contents are only reachable below load_count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rd_data_q <= mem_q[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a checksummed program, then serves CPU fetches
module imem_loader
  import imem_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DFLT,
  parameter int                 INSTR_W   = INSTR_W_DFLT,
  parameter logic [INSTR_W-1:0] FILL_WORD = FILL_WORD_DFLT
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [INSTR_W-1:0] sum_q, sum_d;
  logic               in_ready_q, in_ready_d;
  logic               cpu_run_q, cpu_run_d;
  logic               error_q, error_d;
  logic               hit_q, hit_d;
  logic               xfer;
  logic               wr_en;
  logic [INSTR_W-1:0] rd_data;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    sum_d   = sum_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          wr_en   = 1'b1;
          wptr_d  = wptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W+1)'(1);
          sum_d   = sum_q + bus.in_data;
          if (bus.in_last) begin
            state_d = ST_CHECK;
          end else if (wptr_q == '1) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          state_d = (bus.in_data == sum_q) ? ST_RUN : ST_ERROR;
        end
      end
      default: ;
    endcase

    // Status outputs are registered from the next state so they stay glitch-free.
    in_ready_d = accepts_input(state_d);
    cpu_run_d  = (state_d == ST_RUN);
    error_d    = (state_d == ST_ERROR);
    hit_d      = (state_q == ST_RUN) && (bus.fetch_addr < 16'(count_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      wptr_q     <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      error_q    <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      cpu_run_q  <= cpu_run_d;
      error_q    <= error_d;
      hit_q      <= hit_d;
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (bus.in_data),
    .raddr (bus.fetch_addr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  // RAM read and hit_q are both one cycle behind fetch_addr, so they line up.
  assign bus.fetch_instr = hit_q ? rd_data : FILL_WORD;
  assign bus.in_ready    = in_ready_q;
  assign bus.cpu_run     = cpu_run_q;
  assign bus.error       = error_q;
  assign bus.load_count  = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized and directed bench for imem_loader
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8), .INSTR_W(9)) if8 ();
  imem_loader_if #(.ADDR_W(2), .INSTR_W(9)) if2 ();

  imem_loader #(.ADDR_W(8), .INSTR_W(9), .FILL_WORD(9'h1FF)) dut8 (
    .clk (clk), .reset (rst8), .bus (if8.slave)
  );
  imem_loader #(.ADDR_W(2), .INSTR_W(9), .FILL_WORD(9'h1FF)) dut2 (
    .clk (clk), .reset (rst2), .bus (if2.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] prog[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(int sel);
    return (sel != 0) ? if2.in_ready : if8.in_ready;
  endfunction
  function automatic logic run_o(int sel);
    return (sel != 0) ? if2.cpu_run : if8.cpu_run;
  endfunction
  function automatic logic err_o(int sel);
    return (sel != 0) ? if2.error : if8.error;
  endfunction
  function automatic logic [31:0] cnt_o(int sel);
    return (sel != 0) ? 32'(if2.load_count) : 32'(if8.load_count);
  endfunction
  function automatic logic [31:0] instr_o(int sel);
    return (sel != 0) ? 32'(if2.fetch_instr) : 32'(if8.fetch_instr);
  endfunction

  task automatic drive(int sel, logic v, logic [8:0] d, logic l);
    if (sel != 0) begin
      if2.in_valid = v; if2.in_data = d; if2.in_last = l;
    end else begin
      if8.in_valid = v; if8.in_data = d; if8.in_last = l;
    end
  endtask

  task automatic set_addr(int sel, logic [15:0] a);
    if (sel != 0) if2.fetch_addr = a;
    else          if8.fetch_addr = a;
  endtask

  task automatic set_rst(int sel, logic v);
    if (sel != 0) rst2 = v;
    else          rst8 = v;
  endtask

  // Called at a negedge; returns at a negedge. acc=1 if the word was taken.
  task automatic send_word(int sel, logic [8:0] d, logic l, int bound, output bit acc);
    acc = 1'b0;
    drive(sel, 1'b1, d, l);
    for (int k = 0; k < bound; k++) begin
      if (rdy(sel)) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      @(posedge clk);
      @(negedge clk);
    end
    drive(sel, 1'b0, 9'h000, 1'b0);
  endtask

  task automatic do_reset(int sel);
    @(negedge clk);
    drive(sel, 1'b0, 9'h000, 1'b0);
    set_addr(sel, 16'h0000);
    set_rst(sel, 1'b1);
    @(negedge clk);
    @(negedge clk);
    set_rst(sel, 1'b0);
    @(negedge clk);
  endtask

  task automatic fetch_chk(int sel, logic [15:0] a, logic [8:0] exp, string tag);
    set_addr(sel, a);
    @(negedge clk);
    chk(tag, instr_o(sel), 32'(exp));
  endtask

  function automatic logic [8:0] prog_sum();
    logic [8:0] s = 9'h000;
    foreach (prog[i]) s = s + prog[i];
    return s;
  endfunction

  // Loads prog into a freshly reset DUT and checks the outcome against the rules.
  task automatic load_and_check(int sel, bit corrupt, int gapmax);
    int depth;
    int stored;
    bit overflow;
    bit running;
    bit acc;
    logic [8:0] csum;
    logic [15:0] a;
    logic [8:0] e;
    depth    = (sel != 0) ? 4 : 256;
    overflow = prog.size() > depth;
    stored   = overflow ? depth : prog.size();
    do_reset(sel);
    chk("rand_ready_after_reset", 32'(rdy(sel)), 32'd1);
    for (int i = 0; i < stored; i++) begin
      send_word(sel, prog[i], (i == prog.size() - 1), 4, acc);
      chk("rand_word_accepted", 32'(acc), 32'd1);
      for (int g = $urandom_range(gapmax, 0); g > 0; g--) @(negedge clk);
    end
    if (overflow) begin
      running = 1'b0;
      chk("rand_ovf_error", 32'(err_o(sel)), 32'd1);
      chk("rand_ovf_ready", 32'(rdy(sel)), 32'd0);
    end else begin
      chk("rand_check_ready", 32'(rdy(sel)), 32'd1);
      csum = prog_sum();
      if (corrupt) csum = csum ^ 9'($urandom_range(511, 1));
      send_word(sel, csum, 1'($urandom), 4, acc);
      chk("rand_csum_accepted", 32'(acc), 32'd1);
      running = !corrupt;
      chk("rand_error", 32'(err_o(sel)), 32'(!running));
    end
    chk("rand_run", 32'(run_o(sel)), 32'(running));
    chk("rand_load_count", cnt_o(sel), 32'(stored));
    for (int k = 0; k < 5; k++) begin
      a = (k == 4) ? 16'($urandom) : 16'($urandom_range(prog.size() + 2, 0));
      e = (running && a < prog.size()) ? prog[a] : 9'h1FF;
      fetch_chk(sel, a, e, "rand_fetch");
    end
  endtask

  initial begin
    bit acc;
    drive(0, 1'b0, 9'h000, 1'b0);
    drive(1, 1'b0, 9'h000, 1'b0);
    set_addr(0, 16'h0000);
    set_addr(1, 16'h0000);
    repeat (2) @(negedge clk);

    chk("reset_ready", 32'(if8.in_ready), 32'd0);
    chk("reset_run", 32'(if8.cpu_run), 32'd0);
    chk("reset_error", 32'(if8.error), 32'd0);
    chk("reset_count", 32'(if8.load_count), 32'd0);
    chk("reset_fetch", 32'(if8.fetch_instr), 32'h1FF);
    rst8 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(if8.in_ready), 32'd1);

    // Basic load with correct checksum.
    send_word(0, 9'h012, 1'b0, 4, acc);
    send_word(0, 9'h034, 1'b0, 4, acc);
    send_word(0, 9'h056, 1'b1, 4, acc);
    chk("t1_check_ready", 32'(if8.in_ready), 32'd1);
    chk("t1_not_run_yet", 32'(if8.cpu_run), 32'd0);
    send_word(0, 9'h09C, 1'b0, 4, acc);
    chk("t1_run", 32'(if8.cpu_run), 32'd1);
    chk("t1_ready_closed", 32'(if8.in_ready), 32'd0);
    chk("t1_count", 32'(if8.load_count), 32'd3);
    fetch_chk(0, 16'd0, 9'h012, "t1_fetch0");
    fetch_chk(0, 16'd1, 9'h034, "t1_fetch1");
    fetch_chk(0, 16'd2, 9'h056, "t1_fetch2");
    fetch_chk(0, 16'd3, 9'h1FF, "t1_fetch3");
    fetch_chk(0, 16'h0100, 9'h1FF, "t1_fetch100");

    // Bad checksum is sticky.
    do_reset(0);
    send_word(0, 9'h012, 1'b0, 4, acc);
    send_word(0, 9'h034, 1'b0, 4, acc);
    send_word(0, 9'h056, 1'b1, 4, acc);
    send_word(0, 9'h09D, 1'b0, 4, acc);
    chk("t2_error", 32'(if8.error), 32'd1);
    chk("t2_run", 32'(if8.cpu_run), 32'd0);
    chk("t2_ready", 32'(if8.in_ready), 32'd0);
    fetch_chk(0, 16'd0, 9'h1FF, "t2_fetch0");
    send_word(0, 9'h09C, 1'b0, 3, acc);
    chk("t2_port_closed", 32'(acc), 32'd0);
    chk("t2_error_sticky", 32'(if8.error), 32'd1);

    // Full small memory with in_last on the last slot.
    prog = '{9'h101, 9'h022, 9'h0F3, 9'h144};
    load_and_check(1, 1'b0, 0);
    fetch_chk(1, 16'd3, 9'h144, "t3_fetch_last_slot");
    // Overflow on the small memory.
    prog = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
    load_and_check(1, 1'b0, 0);

    // in_valid toggling every other cycle.
    prog = '{9'h0AA, 9'h155, 9'h1C3, 9'h00F, 9'h111};
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      send_word(0, prog[i], (i == 4), 4, acc);
      @(negedge clk);
    end
    chk("t5_count", 32'(if8.load_count), 32'd5);
    send_word(0, prog_sum(), 1'b0, 4, acc);
    chk("t5_run", 32'(if8.cpu_run), 32'd1);
    for (int i = 0; i < 6; i++)
      fetch_chk(0, 16'(i), (i < 5) ? prog[i] : 9'h1FF, "t5_fetch");

    // Asynchronous reset mid-load.
    do_reset(0);
    send_word(0, 9'h011, 1'b0, 4, acc);
    send_word(0, 9'h022, 1'b0, 4, acc);
    drive(0, 1'b1, 9'h033, 1'b0);
    #1 rst8 = 1'b1;
    #1;
    chk("t6_ready_drop", 32'(if8.in_ready), 32'd0);
    chk("t6_count_clear", 32'(if8.load_count), 32'd0);
    drive(0, 1'b0, 9'h000, 1'b0);
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    chk("t6_ready_back", 32'(if8.in_ready), 32'd1);
    send_word(0, 9'h100, 1'b1, 4, acc);
    send_word(0, 9'h100, 1'b0, 4, acc);
    chk("t6_run", 32'(if8.cpu_run), 32'd1);
    chk("t6_count", 32'(if8.load_count), 32'd1);
    fetch_chk(0, 16'd0, 9'h100, "t6_fetch0");
    fetch_chk(0, 16'd1, 9'h1FF, "t6_fetch1");

    // Randomized programs on both depths.
    for (int it = 0; it < 16; it++) begin
      prog.delete();
      for (int i = $urandom_range(10, 1); i > 0; i--) prog.push_back(9'($urandom));
      load_and_check(0, ($urandom_range(3, 0) == 0), 2);
    end
    for (int it = 0; it < 10; it++) begin
      prog.delete();
      for (int i = $urandom_range(6, 1); i > 0; i--) prog.push_back(9'($urandom));
      load_and_check(1, ($urandom_range(3, 0) == 0), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
